hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Parametrised successor to the single-source load-use comparator: one unit owns all data-hazard handling for the in-order RISC-V pipeline.
- Per source operand, it compares decode-stage (ID) sources against EX/MEM destinations. It produces registered EX-stage forwarding selects, combinational stall/bubble controls, and a multi-cycle load-use stall FSM.
- Sits between the ID/EX pipeline register and the operand muxes. It also exports a saturating stall-event counter for performance monitoring.

Parameters:
- REG_ADDR_W, 5, register-address width.
- NUM_SRC, 2, number of source operands checked (2 for RV32I, 3 for fused multiply-add).
- LOAD_LAT, 1, cycles a load occupies the MEM stage (1..8); sets load-use stall length.
- CNT_W, 16, width of the stall-event counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  NUM_SRC*REG_ADDR_W  ID-stage source addresses; operand i is at bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_rs_used  in  NUM_SRC  operand i is actually read by the ID instruction.
- ex_rd  in  REG_ADDR_W  EX-stage destination.
- ex_reg_write  in  1  EX instruction writes ex_rd.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  REG_ADDR_W  MEM-stage destination.
- mem_reg_write  in  1  MEM instruction writes mem_rd.
- flush  in  1  branch/jump redirect; kills ID and EX.
- fwd_sel  out  2*NUM_SRC  registered select for EX operand i: 00 register file, 01 from MEM result, 10 from WB result.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID register.
- idex_bubble  out  1  load NOP into ID/EX.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Match rule: operand i matches stage S when id_rs_used[i]=1, S reg_write=1, S rd equals rs_i, and rd is not 0. Register x0 never matches.
- Load-use hazard (luh): any operand matches EX while ex_mem_read=1.
- FSM states:
  - IDLE: stall outputs are 1 when luh=1 and flush=0; otherwise 0.
    - If luh=1, flush=0 and LOAD_LAT>1: next state WAIT with cnt=LOAD_LAT-1.
    - Otherwise stay IDLE.
  - WAIT: pc_stall, ifid_stall and idex_bubble are forced to 1.
    - cnt decrements each cycle; the load sits in MEM.
    - When cnt reaches 1, the next state is IDLE.
- Stall length: total stall per load-use is exactly LOAD_LAT cycles; for LOAD_LAT=1 the FSM never leaves IDLE.
- Forwarding select, registered at each rising edge with the next fwd_sel[i]:
  - 00 if flush=1, or if a stall output is 1 (a bubble enters EX).
  - Otherwise 01 if operand i matches EX and ex_mem_read=0.
  - Otherwise 10 if operand i matches MEM.
  - Otherwise 00.
  - EX match has priority over MEM match (youngest producer wins).
- Consumer release: on release from a load-use stall the load is in MEM and the consumer moves to EX, so the MEM match yields 10.
- Flush: forces the FSM to IDLE and stall outputs to 0 in the same cycle; flush has priority over luh and WAIT.
- stall_cnt: increments on every cycle with pc_stall=1; saturates at all-ones and never wraps.
- Reset (reset=0, async): FSM to IDLE, cnt=0, fwd_sel=0, stall_cnt=0. Stall outputs read 0 during reset regardless of inputs.
- Reset asserted mid-WAIT abandons the stall immediately. After reset release, behaviour starts from IDLE.
- Inputs are sampled only at the rising clk edge for registered state; stall outputs are combinational from inputs and state.

Test Plan:
- Reset release with every input 0 -> fwd_sel=0, stall outputs 0, stall_cnt=0.
- ALU producer: ex_rd=5, ex_reg_write=1, ex_mem_read=0, id_rs0=5, id_rs_used=01 -> after the edge fwd_sel[1:0]=01, no stall. Repeat with mem_rd=5 only -> 10. Repeat with both ex_rd=5 and mem_rd=5 -> 01.
- LOAD_LAT=1: load ex_rd=7, id_rs1=7 -> pc_stall=1 for exactly 1 cycle. The next cycle shows mem_rd=7, and fwd_sel[3:2]=10 after the edge. stall_cnt=1.
- LOAD_LAT=3 instance: same load-use -> stall for exactly 3 consecutive cycles, FSM path IDLE-WAIT-WAIT-IDLE, stall_cnt=3. Assert flush during the 2nd cycle -> stall drops that same cycle and fwd_sel=00.
- x0 and unused operand: ex_rd=0 load with id_rs0=0 -> no stall. ex_rd=9 load with id_rs0=9 and id_rs_used=00 -> no stall.
- CNT_W=4 instance: hold a load-use for 20 stall cycles -> stall_cnt stops at 15. Assert reset mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Data-hazard unit for the in-order pipeline. It compares ID-stage sources against
// EX/MEM destinations and drives the forwarding selects, stall controls and load-use FSM.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          ex_reg_write,
    input  logic                          ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic                          mem_reg_write,
    input  logic                          flush,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          pc_stall,
    output logic                          ifid_stall,
    output logic                          idex_bubble,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int LCNT_W = 4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
    logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC-1:0]  match_ex;
    logic [NUM_SRC-1:0]  match_mem;
    logic                luh;
    logic                stall;

    // x0 is hard-wired zero, so a write to it never produces a hazard.
    always_comb begin
        match_ex  = '0;
        match_mem = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            match_ex[i]  = id_rs_used[i] && ex_reg_write && (ex_rd != '0) &&
                           (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd);
            match_mem[i] = id_rs_used[i] && mem_reg_write && (mem_rd != '0) &&
                           (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == mem_rd);
        end
    end

    assign luh = ex_mem_read && (|match_ex);

    // The IDLE cycle supplies the first stall; WAIT covers the remaining LOAD_LAT-1.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        stall   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (luh && !flush) begin
                    stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = S_WAIT;
                        lcnt_d  = LCNT_W'(LOAD_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                    lcnt_d  = '0;
                end else begin
                    stall  = 1'b1;
                    lcnt_d = lcnt_q - LCNT_W'(1);
                    if (lcnt_q <= LCNT_W'(1)) begin
                        state_d = S_IDLE;
                        lcnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                lcnt_d  = '0;
            end
        endcase
        if (!reset) begin
            stall = 1'b0;
        end
    end

    // A stalled or flushed cycle sends a bubble into EX, which needs no forwarding.
    always_comb begin
        fwd_sel_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (flush || stall) begin
                fwd_sel_d[2*i +: 2] = 2'b00;
            end else if (match_ex[i] && !ex_mem_read) begin
                fwd_sel_d[2*i +: 2] = 2'b01;
            end else if (match_mem[i]) begin
                fwd_sel_d[2*i +: 2] = 2'b10;
            end else begin
                fwd_sel_d[2*i +: 2] = 2'b00;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lcnt_q      <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lcnt_q      <= lcnt_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel     = fwd_sel_q;
    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign idex_bubble = stall;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: LOAD_LAT=1, LOAD_LAT=3 and a narrow-counter instance.
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    logic       flush;

    logic [3:0]  a_fwd, b_fwd, c_fwd;
    logic        a_pc, a_ifid, a_bub;
    logic        b_pc, b_ifid, b_bub;
    logic        c_pc, c_ifid, c_bub;
    logic [15:0] a_cnt, b_cnt;
    logic [3:0]  c_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .flush(flush),
        .fwd_sel(a_fwd), .pc_stall(a_pc), .ifid_stall(a_ifid), .idex_bubble(a_bub),
        .stall_cnt(a_cnt)
    );

    hazard_forward_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)) u_l3 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .flush(flush),
        .fwd_sel(b_fwd), .pc_stall(b_pc), .ifid_stall(b_ifid), .idex_bubble(b_bub),
        .stall_cnt(b_cnt)
    );

    hazard_forward_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .flush(flush),
        .fwd_sel(c_fwd), .pc_stall(c_pc), .ifid_stall(c_ifid), .idex_bubble(c_bub),
        .stall_cnt(c_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs         = '0;
        id_rs_used    = '0;
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        mem_rd        = '0;
        mem_reg_write = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
    endtask

    // Load in EX writing x7, consumer reads x7 as operand 1.
    task automatic load_use_x7();
        ex_rd        = 5'd7;
        ex_reg_write = 1'b1;
        ex_mem_read  = 1'b1;
        id_rs        = {5'd7, 5'd0};
        id_rs_used   = 2'b10;
    endtask

    // Load has advanced to MEM, bubble in EX, consumer still in ID.
    task automatic load_in_mem_x7();
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        mem_rd        = 5'd7;
        mem_reg_write = 1'b1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        #2;
        chk("rst_pc_stall", 32'(a_pc), 32'd0);
        chk("rst_fwd", 32'(a_fwd), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("rel_fwd", 32'(a_fwd), 32'd0);
        chk("rel_stall", 32'({a_pc, a_ifid, a_bub}), 32'd0);
        chk("rel_cnt", 32'(a_cnt), 32'd0);

        // ALU producer in EX
        ex_rd        = 5'd5;
        ex_reg_write = 1'b1;
        id_rs        = {5'd0, 5'd5};
        id_rs_used   = 2'b01;
        #1;
        chk("alu_ex_no_stall", 32'(a_pc), 32'd0);
        step();
        chk("alu_ex_fwd", 32'(a_fwd), 32'h1);
        ex_reg_write  = 1'b0;
        mem_rd        = 5'd5;
        mem_reg_write = 1'b1;
        step();
        chk("alu_mem_fwd", 32'(a_fwd), 32'h2);
        ex_reg_write = 1'b1;
        step();
        chk("alu_both_fwd", 32'(a_fwd), 32'h1);

        // LOAD_LAT=1 load-use
        pulse_reset();
        load_use_x7();
        #1;
        chk("l1_stall", 32'({a_pc, a_ifid, a_bub}), 32'h7);
        step();
        chk("l1_stall_fwd", 32'(a_fwd), 32'h0);
        chk("l1_cnt", 32'(a_cnt), 32'd1);
        load_in_mem_x7();
        #1;
        chk("l1_release", 32'(a_pc), 32'd0);
        step();
        chk("l1_release_fwd", 32'(a_fwd), 32'h8);
        chk("l1_cnt_hold", 32'(a_cnt), 32'd1);

        // LOAD_LAT=3 load-use: three stall cycles
        pulse_reset();
        load_use_x7();
        #1;
        chk("l3_stall_c1", 32'(b_pc), 32'd1);
        step();
        load_in_mem_x7();
        #1;
        chk("l3_stall_c2", 32'({b_pc, b_ifid, b_bub}), 32'h7);
        chk("l3_fwd_c2", 32'(b_fwd), 32'h0);
        step();
        chk("l3_stall_c3", 32'(b_pc), 32'd1);
        step();
        chk("l3_stall_c4", 32'(b_pc), 32'd0);
        chk("l3_cnt", 32'(b_cnt), 32'd3);
        step();
        chk("l3_release_fwd", 32'(b_fwd), 32'h8);

        // LOAD_LAT=3 with flush during the second stall cycle
        pulse_reset();
        load_use_x7();
        step();
        load_in_mem_x7();
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'({b_pc, b_ifid, b_bub}), 32'h0);
        step();
        chk("flush_fwd", 32'(b_fwd), 32'h0);
        flush = 1'b0;
        #1;
        chk("flush_idle", 32'(b_pc), 32'd0);
        chk("flush_cnt", 32'(b_cnt), 32'd1);

        // x0 destination and unused operand
        pulse_reset();
        ex_rd        = 5'd0;
        ex_reg_write = 1'b1;
        ex_mem_read  = 1'b1;
        id_rs        = {5'd0, 5'd0};
        id_rs_used   = 2'b01;
        #1;
        chk("x0_no_stall", 32'({a_pc, b_pc}), 32'd0);
        ex_rd      = 5'd9;
        id_rs      = {5'd0, 5'd9};
        id_rs_used = 2'b00;
        #1;
        chk("unused_no_stall", 32'({a_pc, b_pc}), 32'd0);
        step();
        chk("unused_fwd", 32'(a_fwd), 32'h0);

        // Saturation: 20 consecutive stall cycles
        pulse_reset();
        load_use_x7();
        for (int k = 0; k < 20; k++) begin
            step();
        end
        chk("sat_cnt4", 32'(c_cnt), 32'd15);
        chk("sat_cnt16", 32'(a_cnt), 32'd20);
        chk("sat_wait_stall", 32'(c_pc), 32'd1);

        // Asynchronous reset while in WAIT with the hazard still present
        #2;
        reset = 1'b0;
        #1;
        chk("arst_stall", 32'({c_pc, c_ifid, c_bub, a_pc}), 32'h0);
        chk("arst_cnt", 32'(c_cnt), 32'd0);
        chk("arst_fwd", 32'(c_fwd), 32'h0);
        step();
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("post_rst_idle", 32'(c_pc), 32'd0);
        step();
        chk("post_rst_cnt", 32'(c_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
